// File: rtl/bit_reverse_reorder_if.sv
// Handshake bundle between the last SDF stage, the reorder buffer and the downstream consumer.
// Latency: none, wires only.
// Backpressure: o_ready stalls the producer; i_ready stalls the reorder buffer output.
// Ports: config (i_log2_point, i_mode), input stream (i_data/i_valid/o_ready),
// output stream (o_data/o_valid/i_ready/o_last) and status (o_cfg_err, o_bank_sel).
interface bit_reverse_reorder_if #(
  parameter int DWIDTH = 32,
  parameter int LW     = 4
);
  logic [LW-1:0]     i_log2_point;
  logic              i_mode;
  logic [DWIDTH-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready;
  logic              o_last;
  logic              o_cfg_err;
  logic              o_bank_sel;

  // Reorder buffer side.
  modport slave (
    input  i_log2_point, i_mode, i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last, o_cfg_err, o_bank_sel
  );

  // Producer / consumer side.
  modport master (
    output i_log2_point, i_mode, i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_cfg_err, o_bank_sel
  );
endinterface

// File: rtl/bit_reverse_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output order -> natural order (or pass-through).
// Latency: last input accepted at edge T gives first o_valid after edge T+2.
// Backpressure: o_ready low while the write bank is FULL/DRAINING; 2-entry skid absorbs i_ready stalls.
// Ports: clk, reset_n (async active-low) plus the slave side of bit_reverse_reorder_if.
module bit_reverse_reorder #(
  parameter int DWIDTH   = 32,
  parameter int MAX_LOG2 = 10,
  parameter int LW       = $clog2(MAX_LOG2 + 1)
) (
  input logic                  clk,
  input logic                  reset_n,
  bit_reverse_reorder_if.slave bus
);

  localparam int DEPTH = 1 << MAX_LOG2;

  typedef logic [MAX_LOG2-1:0] cnt_t;
  typedef enum logic [1:0] {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING} bank_st_e;

  // Index of the last sample of a 2^l frame.
  function automatic cnt_t last_idx(input logic [LW-1:0] l);
    logic [MAX_LOG2:0] span;
    span = (MAX_LOG2 + 1)'(1) << l;
    return cnt_t'(span - (MAX_LOG2 + 1)'(1));
  endfunction

  // Reverse the low l bits: reverse the whole counter, then shift the
  // reversed field back down (the counter never exceeds 2^l-1).
  function automatic cnt_t bit_rev(input cnt_t cnt, input logic [LW-1:0] l);
    cnt_t full;
    for (int i = 0; i < MAX_LOG2; i++) full[i] = cnt[MAX_LOG2-1-i];
    return full >> (LW'(MAX_LOG2) - l);
  endfunction

  bank_st_e          bank_st_q [2], bank_st_d [2];
  logic [LW-1:0]     bank_l_q [2], bank_l_d [2];
  logic              bank_mode_q [2], bank_mode_d [2];
  logic              wr_bank_q, wr_bank_d;
  cnt_t              wr_cnt_q, wr_cnt_d;
  logic              rd_bank_q, rd_bank_d;
  cnt_t              rd_cnt_q, rd_cnt_d;
  logic              inflight_q, inflight_d;
  logic              rd_last_q, rd_last_d;
  logic [DWIDTH-1:0] sk_dat_q [2], sk_dat_d [2];
  logic              sk_last_q [2], sk_last_d [2];
  logic [1:0]        sk_cnt_q, sk_cnt_d;
  logic              cfg_err_q, cfg_err_d;
  logic [DWIDTH-1:0] rd_dat_q;
  logic [DWIDTH-1:0] mem [2*DEPTH];

  // Write side decode. Config is taken live on the first sample of a frame,
  // from the bank's latched copy afterwards.
  logic          cfg_legal, wr_first, wr_mode, wr_rdy, wr_fire, wr_last;
  logic [LW-1:0] cfg_l, wr_l;
  cnt_t          wr_addr;

  assign cfg_legal = (bus.i_log2_point != '0) && (bus.i_log2_point <= LW'(MAX_LOG2));
  assign cfg_l     = cfg_legal ? bus.i_log2_point : LW'(MAX_LOG2);
  assign wr_first  = (wr_cnt_q == '0);
  assign wr_l      = wr_first ? cfg_l : bank_l_q[wr_bank_q];
  assign wr_mode   = wr_first ? bus.i_mode : bank_mode_q[wr_bank_q];
  assign wr_rdy    = (bank_st_q[wr_bank_q] == BANK_EMPTY) || (bank_st_q[wr_bank_q] == BANK_FILLING);
  assign wr_fire   = bus.i_valid && wr_rdy;
  assign wr_last   = (wr_cnt_q == last_idx(wr_l));
  assign wr_addr   = wr_mode ? wr_cnt_q : bit_rev(wr_cnt_q, wr_l);

  // Read side decode. Credit counts the skid occupancy left after this
  // cycle's pop plus the read already in flight, so a pop frees a slot in
  // the same cycle and one read per cycle is sustained.
  logic       rd_avail, rd_last, rd_issue, sk_pop, sk_slot;
  logic [1:0] occ_after;

  assign rd_avail  = (bank_st_q[rd_bank_q] == BANK_FULL) || (bank_st_q[rd_bank_q] == BANK_DRAINING);
  assign rd_last   = (rd_cnt_q == last_idx(bank_l_q[rd_bank_q]));
  assign sk_pop    = (sk_cnt_q != 2'd0) && bus.i_ready;
  assign occ_after = sk_cnt_q - {1'b0, sk_pop} + {1'b0, inflight_q};
  assign rd_issue  = rd_avail && (occ_after < 2'd2);
  assign sk_slot   = ((sk_cnt_q - {1'b0, sk_pop}) != 2'd0);

  // Bank FSMs and counters. Write and read banks are never the same bank in
  // an active state, so the two updates below never collide.
  always_comb begin
    bank_st_d   = bank_st_q;
    bank_l_d    = bank_l_q;
    bank_mode_d = bank_mode_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    inflight_d  = rd_issue;
    rd_last_d   = rd_issue && rd_last;
    cfg_err_d   = wr_fire && wr_first && !cfg_legal;

    if (wr_fire) begin
      if (wr_first) begin
        bank_l_d[wr_bank_q]    = cfg_l;
        bank_mode_d[wr_bank_q] = bus.i_mode;
      end
      if (wr_last) begin
        bank_st_d[wr_bank_q] = BANK_FULL;
        wr_cnt_d             = '0;
        wr_bank_d            = ~wr_bank_q;
      end else begin
        bank_st_d[wr_bank_q] = BANK_FILLING;
        wr_cnt_d             = wr_cnt_q + cnt_t'(1);
      end
    end

    if (rd_issue) begin
      if (rd_last) begin
        bank_st_d[rd_bank_q] = BANK_EMPTY;
        rd_cnt_d             = '0;
        rd_bank_d            = ~rd_bank_q;
      end else begin
        bank_st_d[rd_bank_q] = BANK_DRAINING;
        rd_cnt_d             = rd_cnt_q + cnt_t'(1);
      end
    end
  end

  // Skid buffer: entry 0 is the head driven onto the output.
  always_comb begin
    sk_dat_d  = sk_dat_q;
    sk_last_d = sk_last_q;
    sk_cnt_d  = sk_cnt_q - {1'b0, sk_pop} + {1'b0, inflight_q};
    if (sk_pop) begin
      sk_dat_d[0]  = sk_dat_q[1];
      sk_last_d[0] = sk_last_q[1];
    end
    if (inflight_q) begin
      sk_dat_d[sk_slot]  = rd_dat_q;
      sk_last_d[sk_slot] = rd_last_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        bank_st_q[i]   <= BANK_EMPTY;
        bank_l_q[i]    <= LW'(MAX_LOG2);
        bank_mode_q[i] <= 1'b0;
        sk_dat_q[i]    <= '0;
        sk_last_q[i]   <= 1'b0;
      end
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
      sk_cnt_q   <= 2'd0;
      cfg_err_q  <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      bank_l_q    <= bank_l_d;
      bank_mode_q <= bank_mode_d;
      sk_dat_q    <= sk_dat_d;
      sk_last_q   <= sk_last_d;
      wr_bank_q   <= wr_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_bank_q   <= rd_bank_d;
      rd_cnt_q    <= rd_cnt_d;
      inflight_q  <= inflight_d;
      rd_last_q   <= rd_last_d;
      sk_cnt_q    <= sk_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Sample RAM, both banks in one array; bank select is the address MSB.
  always_ff @(posedge clk) begin
    if (wr_fire) mem[{wr_bank_q, wr_addr}] <= bus.i_data;
    if (rd_issue) rd_dat_q <= mem[{rd_bank_q, rd_cnt_q}];
  end

  assign bus.o_ready    = wr_rdy;
  assign bus.o_data     = sk_dat_q[0];
  assign bus.o_valid    = (sk_cnt_q != 2'd0);
  assign bus.o_last     = (sk_cnt_q != 2'd0) && sk_last_q[0];
  assign bus.o_cfg_err  = cfg_err_q;
  assign bus.o_bank_sel = rd_bank_q;

endmodule

// File: tb/tb_bit_reverse_reorder.sv
// Directed bench for bit_reverse_reorder: bit-reverse and pass-through frames,
// back-to-back streaming, output stalls, config latch/illegal config and mid-stream reset.
// Outputs are scored against a queue of expected samples built from hand tables.
module tb_bit_reverse_reorder;
  localparam int DW = 32;
  localparam int ML = 10;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  bit_reverse_reorder_if #(.DWIDTH(DW), .LW(LW)) bus ();

  bit_reverse_reorder #(.DWIDTH(DW), .MAX_LOG2(ML), .LW(LW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail = 0;
  int stall_cnt = 0;
  int cfg_err_cnt = 0;
  int frame_idx = 0;
  bit rdy_toggle = 1'b0;

  int unsigned exp_dat_q[$];
  bit          exp_last_q[$];
  int          exp_bank_q[$];

  int rev3 [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int rev4 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int rev_n(input int x, input int l);
    int r = 0;
    for (int i = 0; i < l; i++) if (((x >> i) & 1) != 0) r |= 1 << (l - 1 - i);
    return r;
  endfunction

  function automatic int exp_perm(input int j, input int l, input bit mode);
    if (mode) return j;
    if (l == 3) return rev3[j];
    if (l == 4) return rev4[j];
    return rev_n(j, l);
  endfunction

  // Queue the natural-order output of a frame whose k-th input was base+k.
  task automatic expect_frame(input int base, input int l, input bit mode);
    int n = 1 << l;
    for (int j = 0; j < n; j++) begin
      exp_dat_q.push_back(base + exp_perm(j, l, mode));
      exp_last_q.push_back(j == n - 1);
      exp_bank_q.push_back((j == 0) ? (frame_idx % 2) : -1);
    end
    frame_idx++;
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic push(input int d, input int l, input bit mode);
    int waits = 0;
    bus.i_data       = d;
    bus.i_log2_point = LW'(l);
    bus.i_mode       = mode;
    bus.i_valid      = 1'b1;
    while (!bus.o_ready && waits < 5000) begin
      stall_cnt++;
      waits++;
      @(negedge clk);
    end
    if (!bus.o_ready) check_eq("push_timeout", bus.o_ready, 1);
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int c = 0;
    bus.i_valid = 1'b0;
    while (exp_dat_q.size() != 0 && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, exp_dat_q.size(), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.i_valid = 1'b0;
    rdy_toggle  = 1'b0;
    reset_n     = 1'b0;
    exp_dat_q.delete();
    exp_last_q.delete();
    exp_bank_q.delete();
    frame_idx   = 0;
    stall_cnt   = 0;
    repeat (2) @(negedge clk);
    reset_n     = 1'b1;
    cfg_err_cnt = 0;
    @(negedge clk);
  endtask

  // i_ready: held high, or toggled every cycle when rdy_toggle is set.
  always @(posedge clk) begin
    #1;
    bus.i_ready = rdy_toggle ? ~bus.i_ready : 1'b1;
  end

  // Output monitor: head of queue must be presented whenever o_valid is high
  // (this also covers hold during stalls); it is retired on i_ready.
  always @(negedge clk) begin
    if (reset_n && bus.o_cfg_err) cfg_err_cnt++;
    if (reset_n && bus.o_valid) begin
      if (exp_dat_q.size() == 0) begin
        check_eq("unexpected_out", bus.o_valid, 0);
      end else begin
        check_eq("out_data", bus.o_data, exp_dat_q[0]);
        check_eq("out_last", bus.o_last, exp_last_q[0]);
        if (bus.i_ready) begin
          if (exp_bank_q[0] >= 0) check_eq("bank_sel", bus.o_bank_sel, exp_bank_q[0]);
          void'(exp_dat_q.pop_front());
          void'(exp_last_q.pop_front());
          void'(exp_bank_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_data       = '0;
    bus.i_log2_point = LW'(3);
    bus.i_mode       = 1'b0;
    reset_n          = 1'b1;
    #1 reset_n       = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_valid", bus.o_valid, 0);
    check_eq("rst_last", bus.o_last, 0);
    check_eq("rst_cfg_err", bus.o_cfg_err, 0);
    check_eq("rst_bank_sel", bus.o_bank_sel, 0);
    check_eq("rst_data", bus.o_data, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", bus.o_ready, 1);

    // 1: L=3 bit-reverse, latency of 2 edges after the last input
    expect_frame(0, 3, 1'b0);
    for (int k = 0; k < 8; k++) push(k, 3, 1'b0);
    bus.i_valid = 1'b0;
    check_eq("t1_lat_e0", bus.o_valid, 0);
    @(negedge clk);
    check_eq("t1_lat_e1", bus.o_valid, 0);
    @(negedge clk);
    check_eq("t1_lat_e2", bus.o_valid, 1);
    wait_drain("t1_drain");

    // 2: three back-to-back L=4 frames, no input stall, banks 0,1,0
    do_reset();
    for (int f = 0; f < 3; f++) expect_frame(16 * f, 4, 1'b0);
    for (int k = 0; k < 48; k++) push(k, 4, 1'b0);
    wait_drain("t2_drain");
    check_eq("t2_no_stall", stall_cnt, 0);

    // 3: L=3, i_ready toggling, two frames streamed continuously
    do_reset();
    rdy_toggle = 1'b1;
    expect_frame(100, 3, 1'b0);
    expect_frame(200, 3, 1'b0);
    for (int k = 0; k < 8; k++) push(100 + k, 3, 1'b0);
    for (int k = 0; k < 8; k++) push(200 + k, 3, 1'b0);
    bus.i_valid = 1'b0;
    check_eq("t3_ready_drop", bus.o_ready, 0);
    wait_drain("t3_drain");
    rdy_toggle = 1'b0;

    // 4: pass-through L=5; size change mid-frame is ignored
    do_reset();
    expect_frame(0, 5, 1'b1);
    for (int k = 0; k < 32; k++) push(k, (k < 10) ? 5 : 2, 1'b1);
    bus.i_valid = 1'b0;
    check_eq("t4_lat_e0", bus.o_valid, 0);
    @(negedge clk);
    check_eq("t4_lat_e1", bus.o_valid, 0);
    @(negedge clk);
    check_eq("t4_lat_e2", bus.o_valid, 1);
    wait_drain("t4_drain");

    // 5a: log2_point=0 -> 1024-point bit-reverse frame, single error pulse
    do_reset();
    expect_frame(32'h1000, 10, 1'b0);
    push(32'h1000, 0, 1'b0);
    check_eq("t5a_err_pulse", bus.o_cfg_err, 1);
    push(32'h1001, 0, 1'b0);
    check_eq("t5a_err_clear", bus.o_cfg_err, 0);
    for (int k = 2; k < 1024; k++) push(32'h1000 + k, 0, 1'b0);
    wait_drain("t5a_drain");
    check_eq("t5a_err_count", cfg_err_cnt, 1);

    // 5b: log2_point=11 -> 1024-point pass-through frame
    do_reset();
    expect_frame(32'h2000, 10, 1'b1);
    push(32'h2000, 11, 1'b1);
    check_eq("t5b_err_pulse", bus.o_cfg_err, 1);
    for (int k = 1; k < 1024; k++) push(32'h2000 + k, 11, 1'b1);
    wait_drain("t5b_drain");
    check_eq("t5b_err_count", cfg_err_cnt, 1);

    // 6: reset mid-stream, then a fresh frame with no stale data
    do_reset();
    expect_frame(32'h500, 4, 1'b0);
    expect_frame(32'h600, 4, 1'b0);
    for (int k = 0; k < 16; k++) push(32'h500 + k, 4, 1'b0);
    for (int k = 0; k < 5; k++) push(32'h600 + k, 4, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", bus.o_valid, 0);
    check_eq("t6_rst_data", bus.o_data, 0);
    check_eq("t6_rst_last", bus.o_last, 0);
    do_reset();
    check_eq("t6_ready", bus.o_ready, 1);
    check_eq("t6_bank_sel", bus.o_bank_sel, 0);
    expect_frame(0, 4, 1'b0);
    for (int k = 0; k < 16; k++) push(k, 4, 1'b0);
    wait_drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bit_reverse_reorder.md
Name: bit_reverse_reorder

Overview:
Parametrised ping-pong reorder buffer that converts a bit-reversed-order stream from the R22SDF pipeline into natural order, with optional natural-order pass-through.
Frame size is runtime-selectable up to 2^MAX_LOG2 points.
Sits between the last SDF stage and the downstream consumer.
Adds valid/ready flow control on both sides, so the block can stall the FFT core and absorb downstream backpressure.

Parameters:
DWIDTH, 32, sample width (packed complex I/Q)
MAX_LOG2, 10, log2 of maximum frame size; each bank holds 2^MAX_LOG2 words
LW, $clog2(MAX_LOG2+1), width of i_log2_point

Ports:
clk  in  1  clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
i_log2_point  in  LW  frame size log2; legal range 1..MAX_LOG2
i_mode  in  1  0 = bit-reverse reorder, 1 = natural pass-through (same latency)
i_data  in  DWIDTH  input sample
i_valid  in  1  input sample valid
o_ready  out  1  block can accept a sample this cycle
o_data  out  DWIDTH  output sample
o_valid  out  1  output sample valid
i_ready  in  1  downstream accepts o_data
o_last  out  1  marks the final sample of an output frame
o_cfg_err  out  1  one-cycle pulse on an illegal i_log2_point
o_bank_sel  out  1  bank currently being read

Behaviour:
- Reset (async assert, sync deassert handled externally):
  - o_valid=0, o_last=0, o_cfg_err=0, o_bank_sel=0, o_data=0, o_ready=1 after release.
  - Both banks EMPTY; all counters 0; any partial frame is discarded.
- Config latch:
  - i_log2_point and i_mode are sampled on the first accepted sample of each frame (wr_cnt==0) and held for that frame.
  - Changes mid-frame are ignored until the next frame.
  - Illegal value (0 or >MAX_LOG2) is latched as MAX_LOG2 and pulses o_cfg_err for one cycle.
- Per-bank state machine: EMPTY -> FILLING (first write) -> FULL (last write) -> DRAINING (first read issued) -> EMPTY (last read issued).
  - Each bank latches its own frame size and mode at the start of FILLING.
- Write side:
  - A sample is accepted when i_valid && o_ready.
  - o_ready=1 iff the write bank is EMPTY or FILLING.
  - Write address = wr_cnt bit-reversed over the latched L bits (upper MAX_LOG2-L bits zero) when mode=0; = wr_cnt when mode=1.
  - On wr_cnt==2^L-1: wr_cnt<=0, bank->FULL, write bank toggles.
- Read side:
  - Reads rd_cnt in natural order from the read bank once it is FULL.
  - Memory read is synchronous (1 cycle) and feeds a 2-entry output skid buffer.
  - A read is issued only if skid occupancy plus in-flight reads < 2, which gives full throughput with no data loss under backpressure.
  - o_last is asserted with the sample for rd_cnt==2^L-1.
  - After the final read, the bank->EMPTY and the read bank toggles.
- Latency: the last input sample accepted at cycle T gives o_valid=1 at T+2 (first output), assuming i_ready held high.
- Throughput: one sample per cycle sustained, back-to-back frames, both sides streaming.
- Simultaneous events:
  - A bank going EMPTY (last read) in the same cycle the write side wants it: o_ready rises the next cycle.
  - Write and read of different banks in the same cycle is always permitted.
  - The same bank is never written and read concurrently.
- Output hold: o_data, o_valid and o_last stay stable while o_valid && !i_ready.
- L=1 (2-point) is legal; the bit reversal is identity.

Test Plan:
1. L=3, mode=0, inputs 0..7 streamed -> outputs 0,4,2,6,1,5,3,7; o_last on the 7; first o_valid 2 cycles after last input.
2. L=4, three back-to-back frames (0..15, 16..31, 32..47), i_ready=1 -> o_ready never drops; each output frame is the bit-reversal of its input; o_bank_sel alternates 0,1,0.
3. L=3, i_ready toggled 1010..., two frames input continuously -> no sample lost or duplicated; o_ready drops while both banks are FULL/DRAINING; o_data held when stalled.
4. mode=1, L=5, inputs 0..31 -> outputs 0..31 in order, same 2-cycle latency; change i_log2_point to 2 at sample 10 -> ignored, frame stays 32 points.
5. i_log2_point=0 (and separately 11) -> o_cfg_err single pulse, frame of 1024 points handled.
6. L=4, reset_n asserted after 5 samples of frame 1 and 3 outputs of frame 0 -> outputs cleared immediately; after release a fresh frame 0..15 yields 0,8,4,12,...,15 with no stale data.
